// File: rtl/node_mac_scheduler_pkg.sv
// Shared types and constants for the neuron MAC scheduler.
// Holds the FSM encoding, FP32 constants and default geometry.
package node_mac_scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      BIAS = 2'd2,
      OUT  = 2'd3
   } state_t;

   localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
   localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;

   localparam int N_IN_DEF = 15;
   localparam int AW_DEF   = 4;

endpackage

// File: rtl/node_mac_scheduler_float_mac.sv
// Combinational FP32 multiply-accumulate: sum_o = acc_i + a_i * b_i.
// Denormals flush to zero, results truncate, overflow saturates to inf.
module float_mac (
   input  logic [31:0] acc_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] sum_o
);

   function automatic logic [31:0] float_mult(
      input logic [31:0] a,
      input logic [31:0] b
   );
      logic              s;
      logic [47:0]       p;
      logic signed [9:0] e;
      logic [22:0]       m;
      s = a[31] ^ b[31];
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
         return {s, 31'd0};
      p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e = $signed({2'b00, a[30:23]})
        + $signed({2'b00, b[30:23]}) - 10'sd127;
      if (p[47]) begin
         m = p[46:24];
         e = e + 10'sd1;
      end else begin
         m = p[45:23];
      end
      if (e <= 10'sd0)
         return {s, 31'd0};
      if (e >= 10'sd255)
         return {s, 8'hFF, 23'd0};
      return {s, e[7:0], m};
   endfunction

   function automatic logic [31:0] float_adder(
      input logic [31:0] a,
      input logic [31:0] b
   );
      logic [31:0]       big;
      logic [31:0]       sml;
      logic [7:0]        d;
      logic [24:0]       mb;
      logic [24:0]       ms;
      logic [24:0]       sum;
      logic signed [9:0] e;
      if (a[30:23] == 8'd0)
         return b;
      if (b[30:23] == 8'd0)
         return a;
      if (a[30:0] >= b[30:0]) begin
         big = a;
         sml = b;
      end else begin
         big = b;
         sml = a;
      end
      d  = big[30:23] - sml[30:23];
      mb = {2'b01, big[22:0]};
      ms = {2'b01, sml[22:0]} >> d;
      e  = $signed({2'b00, big[30:23]});
      if (big[31] == sml[31]) begin
         sum = mb + ms;
         if (sum[24]) begin
            sum = sum >> 1;
            e   = e + 10'sd1;
         end
      end else begin
         sum = mb - ms;
         if (sum == 25'd0)
            return 32'd0;
         for (int i = 0; i < 24; i++) begin
            if (!sum[23]) begin
               sum = sum << 1;
               e   = e - 10'sd1;
            end
         end
      end
      if (e <= 10'sd0)
         return {big[31], 31'd0};
      if (e >= 10'sd255)
         return {big[31], 8'hFF, 23'd0};
      return {big[31], e[7:0], sum[22:0]};
   endfunction

   assign sum_o = float_adder(acc_i, float_mult(a_i, b_i));

endmodule

// File: rtl/node_mac_scheduler.sv
// Streams one neuron frame through a shared MAC, adds bias,
// applies ReLU and holds the result until downstream accepts.
module node_mac_scheduler
   import node_mac_scheduler_pkg::*;
#(
   parameter int N_IN = N_IN_DEF,
   parameter int AW   = AW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [31:0]   a_data,
   input  logic          a_last,
   input  logic [31:0]   bias,
   output logic [AW-1:0] w_addr,
   input  logic [31:0]   w_data,
   output logic          y_valid,
   input  logic          y_ready,
   output logic [31:0]   y_data,
   output logic          busy,
   output logic          err_len
);

   localparam int CW = AW + 1;

   state_t        state_q, state_d;
   logic [31:0]   acc_q, acc_d;
   logic [31:0]   bias_q, bias_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          accept;
   logic          last_cnt;
   logic          frame_end;
   logic [31:0]   mac_acc;
   logic [31:0]   mac_a;
   logic [31:0]   mac_b;
   logic [31:0]   mac_sum;

   assign a_ready   = (state_q == IDLE) || (state_q == ACC);
   assign accept    = a_valid && a_ready;
   assign last_cnt  = (cnt_q == CW'(N_IN - 1));
   assign frame_end = accept && (a_last || last_cnt);
   assign err_len   = frame_end && (a_last != last_cnt);
   assign w_addr    = cnt_q[AW-1:0];
   assign busy      = (state_q != IDLE);
   assign y_valid   = (state_q == OUT);
   assign y_data    = (y_valid && !acc_q[31]) ? acc_q : FP32_ZERO;

   // The bias add reuses the MAC by multiplying bias_q by 1.0.
   assign mac_acc = (state_q == IDLE) ? FP32_ZERO : acc_q;
   assign mac_a   = (state_q == BIAS) ? bias_q : a_data;
   assign mac_b   = (state_q == BIAS) ? FP32_ONE : w_data;

   float_mac u_mac (
      .acc_i (mac_acc),
      .a_i   (mac_a),
      .b_i   (mac_b),
      .sum_o (mac_sum)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      bias_d  = bias_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               acc_d   = mac_sum;
               cnt_d   = CW'(1);
               bias_d  = bias;
               state_d = frame_end ? BIAS : ACC;
            end
         end
         ACC: begin
            if (accept) begin
               acc_d = mac_sum;
               cnt_d = cnt_q + 1'b1;
               if (frame_end)
                  state_d = BIAS;
            end
         end
         BIAS: begin
            acc_d   = mac_sum;
            state_d = OUT;
         end
         OUT: begin
            if (y_ready) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= FP32_ZERO;
         bias_q  <= FP32_ZERO;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         bias_q  <= bias_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_node_mac_scheduler.sv
// Directed frame vectors plus reset and stall sequences
// for the neuron MAC scheduler.
module tb_node_mac_scheduler;

   localparam int N_IN = 15;
   localparam int AW   = 4;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          a_valid = 1'b0;
   logic          a_last  = 1'b0;
   logic          y_ready = 1'b1;
   logic [31:0]   a_data  = 32'd0;
   logic [31:0]   bias    = 32'd0;
   logic [31:0]   w_data;
   logic          a_ready;
   logic          y_valid;
   logic          busy;
   logic          err_len;
   logic [AW-1:0] w_addr;
   logic [31:0]   y_data;

   logic [31:0]   wmem [16];

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] w;
      logic [31:0] b;
      logic [31:0] y;
      int          nb;
      int          last_at;
      int          gap;
      int          stall;
      logic        err;
   } vec_t;

   vec_t vecs [7];

   always #5 clk = ~clk;

   assign w_data = wmem[w_addr];

   node_mac_scheduler #(.N_IN(N_IN), .AW(AW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a_valid (a_valid),
      .a_ready (a_ready),
      .a_data  (a_data),
      .a_last  (a_last),
      .bias    (bias),
      .w_addr  (w_addr),
      .w_data  (w_data),
      .y_valid (y_valid),
      .y_ready (y_ready),
      .y_data  (y_data),
      .busy    (busy),
      .err_len (err_len)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_frame(input vec_t v, input string tag);
      for (int k = 0; k < 16; k++) wmem[k] = v.w;
      for (int i = 0; i < v.nb; i++) begin
         @(negedge clk);
         a_valid = 1'b1;
         a_data  = v.a;
         bias    = (i == 0) ? v.b : 32'hDEAD_BEEF;
         a_last  = (i == v.last_at);
         #1;
         chk({tag, ".w_addr"}, 32'(w_addr), 32'(i));
         chk({tag, ".a_ready"}, 32'(a_ready), 32'd1);
         chk({tag, ".err_len"}, 32'(err_len),
             (i == v.nb - 1) ? 32'(v.err) : 32'd0);
         if (i == v.gap) begin
            repeat (2) begin
               @(negedge clk);
               a_valid = 1'b0;
               a_data  = 32'hFFFF_FFFF;
               a_last  = 1'b1;
               #1;
               chk({tag, ".gap_addr"}, 32'(w_addr), 32'(i + 1));
               chk({tag, ".gap_err"}, 32'(err_len), 32'd0);
            end
         end
      end
      @(negedge clk);
      a_valid = 1'b0;
      a_last  = 1'b0;
      #1;
      chk({tag, ".bias_busy"}, 32'(busy), 32'd1);
      chk({tag, ".bias_yv"}, 32'(y_valid), 32'd0);
      chk({tag, ".bias_ardy"}, 32'(a_ready), 32'd0);
      for (int k = 0; k <= v.stall; k++) begin
         @(negedge clk);
         a_valid = (k < v.stall);
         a_data  = 32'h3F80_0000;
         y_ready = (k == v.stall);
         #1;
         chk({tag, ".y_valid"}, 32'(y_valid), 32'd1);
         chk({tag, ".y_data"}, y_data, v.y);
         chk({tag, ".out_ardy"}, 32'(a_ready), 32'd0);
      end
      @(negedge clk);
      a_valid = 1'b0;
      y_ready = 1'b1;
      #1;
      chk({tag, ".idle_yv"}, 32'(y_valid), 32'd0);
      chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
      chk({tag, ".idle_ardy"}, 32'(a_ready), 32'd1);
      chk({tag, ".idle_addr"}, 32'(w_addr), 32'd0);
   endtask

   initial begin
      vecs[0] = '{a: 32'h3F80_0000, w: 32'h3F80_0000, b: 32'h0,
                  y: 32'h4170_0000, nb: 15, last_at: 14, gap: -1,
                  stall: 0, err: 1'b0};
      vecs[1] = '{a: 32'h3F80_0000, w: 32'hBF80_0000, b: 32'h0,
                  y: 32'h0000_0000, nb: 15, last_at: 14, gap: -1,
                  stall: 0, err: 1'b0};
      vecs[2] = '{a: 32'h0000_0000, w: 32'h3F80_0000, b: 32'h3F00_0000,
                  y: 32'h3F00_0000, nb: 15, last_at: 14, gap: -1,
                  stall: 0, err: 1'b0};
      vecs[3] = '{a: 32'h3F80_0000, w: 32'h3F80_0000, b: 32'h0,
                  y: 32'h40A0_0000, nb: 5, last_at: 4, gap: 1,
                  stall: 3, err: 1'b1};
      vecs[4] = '{a: 32'h4000_0000, w: 32'h4040_0000, b: 32'h3F80_0000,
                  y: 32'h40E0_0000, nb: 1, last_at: 0, gap: -1,
                  stall: 0, err: 1'b1};
      vecs[5] = '{a: 32'h3F80_0000, w: 32'h3F80_0000, b: 32'h0,
                  y: 32'h4170_0000, nb: 15, last_at: -1, gap: -1,
                  stall: 0, err: 1'b1};
      vecs[6] = '{a: 32'h3FC0_0000, w: 32'h4000_0000, b: 32'hBF80_0000,
                  y: 32'h4100_0000, nb: 3, last_at: 2, gap: -1,
                  stall: 1, err: 1'b1};
      for (int k = 0; k < 16; k++) wmem[k] = 32'h3F80_0000;

      repeat (2) @(negedge clk);
      #1;
      chk("rst.y_valid", 32'(y_valid), 32'd0);
      chk("rst.y_data", y_data, 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.err_len", 32'(err_len), 32'd0);
      chk("rst.w_addr", 32'(w_addr), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("rst.a_ready", 32'(a_ready), 32'd1);

      for (int n = 0; n < 7; n++)
         run_frame(vecs[n], $sformatf("v%0d", n));

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         a_valid = 1'b1;
         a_data  = 32'h3F80_0000;
         a_last  = 1'b0;
         bias    = 32'h3F80_0000;
      end
      @(negedge clk);
      a_valid = 1'b0;
      chk("mid.pre_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid.busy", 32'(busy), 32'd0);
      chk("mid.y_valid", 32'(y_valid), 32'd0);
      chk("mid.y_data", y_data, 32'd0);
      chk("mid.w_addr", 32'(w_addr), 32'd0);
      chk("mid.err_len", 32'(err_len), 32'd0);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("mid.a_ready", 32'(a_ready), 32'd1);
      run_frame(vecs[0], "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/node_mac_scheduler.md
NODE_MAC_SCHEDULER -- requirements
Module: node_mac_scheduler

Interface
REQ-001 Parameter N_IN, default 15, number of activations per neuron frame (1..16).
REQ-002 Parameter AW, default 4, weight address width; 2^AW SHALL be >= N_IN.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 a_valid  in  1  activation beat valid.
REQ-006 a_ready  out  1  block accepts the activation beat.
REQ-007 a_data  in  32  IEEE-754 single activation.
REQ-008 a_last  in  1  marks final activation beat of the frame.
REQ-009 bias  in  32  IEEE-754 bias; sampled on the first accepted beat of a frame.
REQ-010 w_addr  out  AW  weight index of the current beat.
REQ-011 w_data  in  32  IEEE-754 weight; combinational lookup of w_addr, same cycle.
REQ-012 y_valid  out  1  neuron result valid.
REQ-013 y_ready  in  1  downstream accepts the result.
REQ-014 y_data  out  32  ReLU'd neuron result.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 err_len  out  1  one-cycle pulse on frame length mismatch.

Function
REQ-017 FSM states SHALL be IDLE, ACC, BIAS, OUT.
REQ-018 a_ready SHALL be 1 in IDLE and ACC, 0 in BIAS and OUT.
REQ-019 Beat accepted when a_valid && a_ready; w_addr SHALL equal the beat count (0 for the first beat of a frame).
REQ-020 Accepted beat in IDLE: acc <= a_data*w_data (multiplied against +0), count <= 1, bias_q <= bias, go ACC.
REQ-021 Accepted beat in ACC: acc <= acc + a_data*w_data, count <= count+1.
REQ-022 Multiply and add SHALL use the codebase float_mult and float_adder units, one product and one add per cycle.
REQ-023 Frame ends on the beat where a_last==1 or count==N_IN-1, whichever comes first; next state BIAS.
REQ-024 err_len SHALL pulse for one cycle on the ending beat if a_last and (count==N_IN-1) disagree.
REQ-025 BIAS: acc <= acc + bias_q, next state OUT (one cycle).
REQ-026 OUT: y_valid=1; y_data = acc if acc[31]==0, else 32'h00000000; y_data SHALL be held stable while y_ready==0.
REQ-027 OUT with y_ready==1: go IDLE, count <= 0; the next frame cannot start in the same cycle.
REQ-028 Latency: y_valid SHALL rise exactly 2 cycles after the cycle in which the ending beat is accepted.
REQ-029 Gaps (a_valid==0) in ACC SHALL hold acc and count unchanged.
REQ-030 In a single-beat frame (a_last on the first beat), IDLE SHALL go directly to BIAS.

Reset
REQ-031 rst_n low SHALL force IDLE asynchronously, including mid-frame; the partial frame is discarded.
REQ-032 Reset values: acc=0, count=0, bias_q=0, y_valid=0, y_data=0, busy=0, err_len=0, w_addr=0; a_ready=1 after reset release.

Structure
REQ-033 Shared package SHALL hold the FSM state typedef, FP32_ZERO constant and default N_IN/AW.
REQ-034 A single sub-module float_mac (float_mult feeding float_adder, combinational) SHALL be instantiated once; no other hierarchy.

Verification
REQ-035 w_data=3F800000 and a_data=3F800000 for all 15 beats, bias=0 -> y_data=41700000 (15.0), err_len never high.
REQ-036 Same stimulus with w_data=BF800000 -> y_data=00000000 (ReLU clamp).
REQ-037 a_data=0 for all beats, bias=3F000000 -> y_data=3F000000 (0.5).
REQ-038 All-ones data, a_last on beat 4 -> err_len pulse on that beat; y_data=40A00000 (5.0); y_valid 2 cycles later.
REQ-039 y_ready held 0 for 3 cycles in OUT -> y_valid, y_data stable, a_ready=0; IDLE on the 4th cycle with y_ready=1.
REQ-040 rst_n pulsed low after beat 7 -> all outputs at reset values immediately; next full frame gives 41700000.
